ps2_rx_controller: RTL and testbench

Sequencer for the PS/2 byte receiver. It synchronizes the raw PS/2 lines and generates the receiver's clock-edge pulses. It detects start bits to arm the receiver and clears the receiver's sticky strobe after every byte. A watchdog recovers from stalled frames, and set-2 scan bytes are assembled into key events on a valid/ready output toward the Morse encoder.

---
 rtl/ps2_rx_controller.sv | 196 +++++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_controller.sv
// PS/2 receive sequencer: line synchronizer, frame FSM with watchdog, and
// set-2 prefix decoder handing key events to a valid/ready consumer.
module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_raw,
    input  logic       ps2_data_raw,
    output logic       rx_clk_posedge,
    output logic       rx_data,
    output logic       rx_start,
    output logic       rx_rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_strb,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_overrun,
    output logic       frame_error,
    output logic [2:0] o_dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // Abort fires on the increment that would land on TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_START   = 3'd1,
        FS_ARM     = 3'd2,
        FS_RECEIVE = 3'd3,
        FS_CLEAR   = 3'd4
    } fs_state_t;

    fs_state_t r_state;
    fs_state_t w_state_next;

    logic r_clk_meta, r_clk_s, r_clk_prev;
    logic r_data_meta, r_data_s;
    logic w_rise, w_fall, w_edge;

    logic [CW-1:0] r_count;
    logic          w_to_hit;
    logic          w_timeout;
    logic          w_latch;

    logic [7:0] r_byte_q;
    logic       r_byte_new;
    logic       r_ext_flag, r_rel_flag;
    logic [7:0] r_key_code;
    logic       r_key_ext, r_key_rel, r_key_valid, r_key_overrun;
    logic       w_is_e0, w_is_f0, w_event, w_slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_s     <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_s    <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_raw;
            r_clk_s     <= r_clk_meta;
            r_clk_prev  <= r_clk_s;
            r_data_meta <= ps2_data_raw;
            r_data_s    <= r_data_meta;
        end
    end

    assign w_rise         = r_clk_s & ~r_clk_prev;
    assign w_fall         = ~r_clk_s & r_clk_prev;
    assign w_edge         = w_rise | w_fall;
    assign rx_clk_posedge = w_rise;
    assign rx_data        = r_data_s;
    assign w_to_hit       = (r_count == TO_LAST) && !w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FS_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        w_latch      = 1'b0;
        rx_start     = 1'b0;
        case (r_state)
            FS_IDLE: begin
                if (w_fall && !r_data_s) w_state_next = FS_START;
            end
            FS_START: begin
                if (w_rise) begin
                    w_state_next = FS_ARM;
                end else if (w_to_hit) begin
                    w_state_next = FS_CLEAR;
                    w_timeout    = 1'b1;
                end
            end
            FS_ARM: begin
                rx_start     = 1'b1;
                w_state_next = FS_RECEIVE;
            end
            FS_RECEIVE: begin
                // A byte completing on the timeout cycle is still delivered.
                if (rx_byte_strb) begin
                    w_latch      = 1'b1;
                    w_state_next = FS_CLEAR;
                end else if (w_to_hit) begin
                    w_state_next = FS_CLEAR;
                    w_timeout    = 1'b1;
                end
            end
            FS_CLEAR: begin
                w_state_next = FS_IDLE;
            end
            default: begin
                w_state_next = FS_IDLE;
            end
        endcase
    end

    assign rx_rst      = rst | (r_state == FS_CLEAR);
    assign frame_error = w_timeout;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_edge || r_state == FS_IDLE || r_state == FS_CLEAR) begin
            r_count <= '0;
        end else if (r_state == FS_START || r_state == FS_RECEIVE) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_q   <= 8'h00;
            r_byte_new <= 1'b0;
        end else begin
            r_byte_new <= w_latch;
            if (w_latch) r_byte_q <= rx_byte;
        end
    end

    assign w_is_e0     = (r_byte_q == 8'hE0);
    assign w_is_f0     = (r_byte_q == 8'hF0);
    assign w_event     = r_byte_new && !w_is_e0 && !w_is_f0;
    assign w_slot_free = !r_key_valid || key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_flag    <= 1'b0;
            r_rel_flag    <= 1'b0;
            r_key_code    <= 8'h00;
            r_key_ext     <= 1'b0;
            r_key_rel     <= 1'b0;
            r_key_valid   <= 1'b0;
            r_key_overrun <= 1'b0;
        end else begin
            r_key_overrun <= 1'b0;
            if (w_timeout) begin
                r_ext_flag <= 1'b0;
                r_rel_flag <= 1'b0;
            end else if (r_byte_new) begin
                if (w_is_e0) begin
                    r_ext_flag <= 1'b1;
                end else if (w_is_f0) begin
                    r_rel_flag <= 1'b1;
                end else begin
                    r_ext_flag <= 1'b0;
                    r_rel_flag <= 1'b0;
                end
            end
            if (w_event && w_slot_free) begin
                r_key_code  <= r_byte_q;
                r_key_ext   <= r_ext_flag;
                r_key_rel   <= r_rel_flag;
                r_key_valid <= 1'b1;
            end else begin
                if (w_event) r_key_overrun <= 1'b1;
                if (r_key_valid && key_ready) r_key_valid <= 1'b0;
            end
        end
    end

    assign key_code     = r_key_code;
    assign key_extended = r_key_ext;
    assign key_release  = r_key_rel;
    assign key_valid    = r_key_valid;
    assign key_overrun  = r_key_overrun;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Bench for ps2_rx_controller: PS/2 line driver, behavioural byte receiver,
// and a scoreboard that checks every accepted key event.
module tb_ps2_rx_controller;

  localparam int TO   = 4000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_raw = 1'b1;
  logic       ps2_data_raw = 1'b1;
  logic       rx_clk_posedge, rx_data, rx_start, rx_rst;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_byte_strb = 1'b0;
  logic [7:0] key_code;
  logic       key_extended, key_release, key_valid;
  logic       key_ready = 1'b1;
  logic       key_overrun, frame_error;
  logic [2:0] dbg_state;

  ps2_rx_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_raw(ps2_clk_raw), .ps2_data_raw(ps2_data_raw),
    .rx_clk_posedge(rx_clk_posedge), .rx_data(rx_data),
    .rx_start(rx_start), .rx_rst(rx_rst),
    .rx_byte(rx_byte), .rx_byte_strb(rx_byte_strb),
    .key_code(key_code), .key_extended(key_extended),
    .key_release(key_release), .key_valid(key_valid),
    .key_ready(key_ready), .key_overrun(key_overrun),
    .frame_error(frame_error), .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  int start_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, kv_hi_cnt = 0;
  int ferr_cyc = 0, rise_cyc = 0, rst_rise_cyc = 0, kv_rise_cyc = 0, strb_cyc = 0;
  logic prev_rx_rst = 1'b1;
  logic prev_kv = 1'b0;

  // behavioural receiver: samples rx_data on each rx_clk_posedge after arming
  int m_cnt = 0;
  logic m_armed = 1'b0;
  logic [7:0] m_shift = 8'h00;
  always @(negedge clk) begin
    if (rx_rst) begin
      m_cnt = 0;
      m_armed = 1'b0;
      m_shift = 8'h00;
      rx_byte_strb = 1'b0;
    end else if (rx_start) begin
      m_armed = 1'b1;
      m_cnt = 0;
    end else if (m_armed && rx_clk_posedge) begin
      if (m_cnt < 8) m_shift[m_cnt] = rx_data;
      m_cnt++;
      if (m_cnt == 10) begin
        rx_byte = m_shift;
        rx_byte_strb = 1'b1;
        m_armed = 1'b0;
        strb_cyc = cyc;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [9:0] exp;
    if (rx_start) start_cnt++;
    if (frame_error) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (key_overrun) ovr_cnt++;
    if (rx_clk_posedge) rise_cyc = cyc;
    if (rx_rst && !prev_rx_rst) rst_rise_cyc = cyc;
    prev_rx_rst = rx_rst;
    if (key_valid && !prev_kv) kv_rise_cyc = cyc;
    prev_kv = key_valid;
    if (key_valid) kv_hi_cnt++;
    if (key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected actual=%h required=none", {key_extended, key_release, key_code});
      end else begin
        exp = exp_q.pop_front();
        if ({key_extended, key_release, key_code} !== exp) begin
          failures++;
          $display("FAIL event actual=%h required=%h", {key_extended, key_release, key_code}, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data_raw = b;
    step(HALF / 2);
    ps2_clk_raw = 1'b0;
    step(HALF);
    ps2_clk_raw = 1'b1;
    step(HALF / 2);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_partial(b, 8);
    ps2_bit(~^b);
    ps2_bit(1'b1);
    step(HALF);
  endtask

  task automatic push_exp(input logic ext, input logic rel, input logic [7:0] code);
    exp_q.push_back({ext, rel, code});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    start_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; kv_hi_cnt = 0;
  endtask

  task automatic check_reset_outs();
    @(negedge clk);
    chk("rst_posedge", rx_clk_posedge, 0);
    chk("rst_rx_data", rx_data, 1);
    chk("rst_rx_start", rx_start, 0);
    chk("rst_rx_rst", rx_rst, 1);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_key_ext", key_extended, 0);
    chk("rst_key_rel", key_release, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_overrun", key_overrun, 0);
    chk("rst_frame_error", frame_error, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    step(3);
    check_reset_outs();
    rst = 1'b0;
    step(5);

    // single make code, immediately accepted
    clear_counts();
    push_exp(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C);
    wait_drain(3000);
    step(5);
    chk("start_once", start_cnt, 1);
    chk("strb_to_rxrst", rst_rise_cyc - strb_cyc, 1);
    chk("strb_to_valid", kv_rise_cyc - strb_cyc, 2);
    chk("valid_one_cycle", kv_hi_cnt, 1);

    // break code
    clear_counts();
    push_exp(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    wait_drain(3000);
    step(5);
    chk("f0_single_event", kv_hi_cnt, 1);

    // extended break code
    clear_counts();
    push_exp(1'b1, 1'b1, 8'h74);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h74);
    wait_drain(3000);
    step(5);
    chk("e0f0_single_event", kv_hi_cnt, 1);

    // stalled frame
    clear_counts();
    send_partial(8'h29, 4);
    ps2_data_raw = 1'b1;
    n = 0;
    while (ferr_cnt == 0 && n < TO + 200) begin
      step(1);
      n++;
    end
    step(5);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_latency", ferr_cyc - rise_cyc, TO - 1);
    chk("ferr_to_rxrst", rst_rise_cyc - ferr_cyc, 1);
    chk("ferr_no_event", kv_hi_cnt, 0);
    push_exp(1'b0, 1'b0, 8'h29);
    send_frame(8'h29);
    wait_drain(3000);

    // consumer stalled: second event dropped
    step(5);
    clear_counts();
    key_ready = 1'b0;
    push_exp(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C);
    send_frame(8'h32);
    step(10);
    chk("overrun_count", ovr_cnt, 1);
    @(negedge clk);
    chk("held_valid", key_valid, 1);
    chk("held_code", key_code, 8'h1C);
    @(posedge clk);
    #1;
    key_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_cleared", key_valid, 0);
    chk("overrun_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // reset in the middle of a frame
    step(5);
    send_partial(8'hAB, 5);
    rst = 1'b1;
    ps2_clk_raw = 1'b1;
    ps2_data_raw = 1'b1;
    step(2);
    check_reset_outs();
    step(3);
    @(negedge clk);
    chk("rxrst_during_rst", rx_rst, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(5);
    push_exp(1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A);
    wait_drain(3000);

    step(20);
    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
